// File: rtl/dice_stats.sv
// Dice statistics block: watches the roller button, captures the settled
// face after release, flags timeouts on illegal values, and keeps per-face
// counts, a throw count and a running pip total (all saturating).
module dice_stats #(
   parameter int CNT_W = 8,
   parameter int SUM_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic [2:0]       throw,
   input  logic             clear,
   input  logic [2:0]       sel,
   output logic             busy,
   output logic [2:0]       result,
   output logic             result_valid,
   output logic             error,
   output logic [CNT_W-1:0] count_sel,
   output logic [CNT_W-1:0] num_throws,
   output logic [SUM_W-1:0] total
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROLLING = 2'd1,
      SETTLE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SUM_W-1:0] SUM_MAX = '1;

   state_t           state_q, state_d;
   logic             button_q;
   logic             armed_q;
   logic [1:0]       settle_cnt_q;
   logic [2:0]       result_q;
   logic             result_valid_q;
   logic             error_q;
   logic [CNT_W-1:0] face_cnt_q [6];
   logic [CNT_W-1:0] num_throws_q;
   logic [SUM_W-1:0] total_q;
   logic [CNT_W-1:0] count_sel_q;

   logic             rise;
   logic             fall;
   logic             legal;
   logic             capture;
   logic             timeout;
   logic [SUM_W:0]   total_sum;

   // armed_q blocks a roll from starting until the button has been seen low
   // at least once after reset, so a button held through reset cannot roll.
   assign rise    = button & ~button_q & armed_q;
   assign fall    = ~button & button_q;
   assign legal   = (throw != 3'd0) && (throw != 3'd7);
   assign capture = (state_q == SETTLE) && legal;
   assign timeout = (state_q == SETTLE) && !legal && (settle_cnt_q == 2'd2);

   // Widened add so saturation can be detected from the carry bit.
   assign total_sum = {1'b0, total_q} + {{(SUM_W-2){1'b0}}, throw};

   // Button edge-detect register and post-reset arming flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         button_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         button_q <= button;
         if (!button) begin
            armed_q <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; button activity in SETTLE is deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = ROLLING;
            end
         end
         ROLLING: begin
            if (fall) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (capture || timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy follows the registered state.
   always_comb begin
      busy = 1'b0;
      if ((state_q == ROLLING) || (state_q == SETTLE)) begin
         busy = 1'b1;
      end
   end

   // Settle wait counter: counts illegal SETTLE cycles, cleared elsewhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle_cnt_q <= 2'd0;
      end else if ((state_q == SETTLE) && !capture && !timeout) begin
         settle_cnt_q <= settle_cnt_q + 2'd1;
      end else begin
         settle_cnt_q <= 2'd0;
      end
   end

   // Captured result and the one-cycle completion / timeout pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q       <= 3'd0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         result_valid_q <= capture;
         error_q        <= timeout;
         if (capture) begin
            result_q <= throw;
         end
      end
   end

   // Statistics: clear has priority over a coincident capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) begin
            face_cnt_q[i] <= '0;
         end
         num_throws_q <= '0;
         total_q      <= '0;
      end else if (clear) begin
         for (int i = 0; i < 6; i++) begin
            face_cnt_q[i] <= '0;
         end
         num_throws_q <= '0;
         total_q      <= '0;
      end else if (capture) begin
         for (int i = 0; i < 6; i++) begin
            if ((throw == 3'(i + 1)) && (face_cnt_q[i] != CNT_MAX)) begin
               face_cnt_q[i] <= face_cnt_q[i] + 1'b1;
            end
         end
         if (num_throws_q != CNT_MAX) begin
            num_throws_q <= num_throws_q + 1'b1;
         end
         if (total_sum[SUM_W]) begin
            total_q <= SUM_MAX;
         end else begin
            total_q <= total_sum[SUM_W-1:0];
         end
      end
   end

   // Registered per-face readout; faces 0 and 7 do not exist and read as 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_sel_q <= '0;
      end else begin
         case (sel)
            3'd1:    count_sel_q <= face_cnt_q[0];
            3'd2:    count_sel_q <= face_cnt_q[1];
            3'd3:    count_sel_q <= face_cnt_q[2];
            3'd4:    count_sel_q <= face_cnt_q[3];
            3'd5:    count_sel_q <= face_cnt_q[4];
            3'd6:    count_sel_q <= face_cnt_q[5];
            default: count_sel_q <= '0;
         endcase
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign error        = error_q;
   assign count_sel    = count_sel_q;
   assign num_throws   = num_throws_q;
   assign total        = total_q;

endmodule

// File: tb/tb_dice_stats.sv
// Self-checking bench for dice_stats: a scoreboard queue holds the expected
// capture/timeout events, a negedge monitor pops and compares them, and the
// scenario tasks check latency, statistics and reset behaviour inline.
module tb_dice_stats;

   localparam int CNT_W = 8;
   localparam int SUM_W = 12;

   logic             clk;
   logic             rst;
   logic             button;
   logic [2:0]       throw;
   logic             clear;
   logic [2:0]       sel;
   logic             busy;
   logic [2:0]       result;
   logic             result_valid;
   logic             error;
   logic [CNT_W-1:0] count_sel;
   logic [CNT_W-1:0] num_throws;
   logic [SUM_W-1:0] total;

   typedef struct packed {
      logic       is_err;
      logic [2:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic [2:0] last_result = 3'd0;

   dice_stats #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .button      (button),
      .throw       (throw),
      .clear       (clear),
      .sel         (sel),
      .busy        (busy),
      .result      (result),
      .result_valid(result_valid),
      .error       (error),
      .count_sel   (count_sel),
      .num_throws  (num_throws),
      .total       (total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      exp_t e;
      if (rst && (result_valid || error)) begin
         checks++;
         if ((result_valid && error) !== 1'b0) begin
            failures++;
            $display("FAIL pulse_overlap rv=%0b err=%0b required not both", result_valid, error);
         end
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected rv=%0b err=%0b result=%0d required no event", result_valid, error, result);
         end else begin
            e = sb_q.pop_front();
            if ({error, result} !== {e.is_err, e.val}) begin
               failures++;
               $display("FAIL sb_event got err=%0b result=%0d required err=%0b result=%0d", error, result, e.is_err, e.val);
            end
         end
      end
   end

   // Press for 'press' cycles with 'face' on throw, then release at a negedge.
   task automatic do_roll(input int press, input logic [2:0] face);
      @(negedge clk);
      button = 1'b1;
      throw  = face;
      repeat (press) @(negedge clk);
      button = 1'b0;
   endtask

   task automatic push_capture(input logic [2:0] face);
      exp_t e;
      e.is_err = 1'b0;
      e.val    = face;
      sb_q.push_back(e);
      last_result = face;
   endtask

   task automatic test_reset();
      rst = 1'b0; button = 1'b0; throw = 3'd0; clear = 1'b0; sel = 3'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, result, result_valid, error} !== 6'd0) begin
         failures++;
         $display("FAIL reset_ctrl got busy=%0b result=%0d rv=%0b err=%0b required all 0", busy, result, result_valid, error);
      end
      checks++;
      if ({count_sel, num_throws, total} !== '0) begin
         failures++;
         $display("FAIL reset_stats got cs=%0d nt=%0d tot=%0d required 0", count_sel, num_throws, total);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      do_roll(5, 3'd4);
      push_capture(3'd4);
      @(posedge clk); #1;
      checks++;
      if ({busy, result_valid} !== 2'b10) begin
         failures++;
         $display("FAIL basic_settle got busy=%0b rv=%0b required busy=1 rv=0", busy, result_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({result_valid, result} !== {1'b1, 3'd4}) begin
         failures++;
         $display("FAIL basic_latency got rv=%0b result=%0d required rv=1 result=4", result_valid, result);
      end
      @(posedge clk); #1;
      checks++;
      if ({result_valid, busy} !== 2'b00) begin
         failures++;
         $display("FAIL basic_pulse got rv=%0b busy=%0b required 0 0", result_valid, busy);
      end
      sel = 3'd4;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({num_throws, total, count_sel} !== {8'd1, 12'd4, 8'd1}) begin
         failures++;
         $display("FAIL basic_stats got nt=%0d tot=%0d cs4=%0d required 1 4 1", num_throws, total, count_sel);
      end
   endtask

   task automatic test_illegal_then_legal();
      do_roll(3, 3'd7);
      push_capture(3'd1);
      @(posedge clk);   // enters SETTLE
      @(posedge clk);   // first SETTLE edge sees 7
      @(negedge clk);
      throw = 3'd1;
      @(posedge clk); #1;
      checks++;
      if ({result_valid, error, result} !== {1'b1, 1'b0, 3'd1}) begin
         failures++;
         $display("FAIL late_legal got rv=%0b err=%0b result=%0d required 1 0 1", result_valid, error, result);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({num_throws, total} !== {8'd2, 12'd5}) begin
         failures++;
         $display("FAIL late_legal_stats got nt=%0d tot=%0d required 2 5", num_throws, total);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      do_roll(2, 3'd0);
      e.is_err = 1'b1;
      e.val    = last_result;
      sb_q.push_back(e);
      @(posedge clk);                // enters SETTLE
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({error, busy} !== 2'b01) begin
         failures++;
         $display("FAIL timeout_early got err=%0b busy=%0b required err=0 busy=1", error, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({error, result_valid, busy, result} !== {3'b100, last_result}) begin
         failures++;
         $display("FAIL timeout_pulse got err=%0b rv=%0b busy=%0b result=%0d required 1 0 0 %0d", error, result_valid, busy, result, last_result);
      end
      @(posedge clk); #1;
      checks++;
      if ({error, num_throws, total} !== {1'b0, 8'd2, 12'd5}) begin
         failures++;
         $display("FAIL timeout_after got err=%0b nt=%0d tot=%0d required 0 2 5", error, num_throws, total);
      end
   endtask

   task automatic test_clear_on_capture();
      do_roll(2, 3'd3);
      push_capture(3'd3);
      @(posedge clk);   // enters SETTLE
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({result_valid, result} !== {1'b1, 3'd3}) begin
         failures++;
         $display("FAIL clear_capture got rv=%0b result=%0d required 1 3", result_valid, result);
      end
      @(negedge clk);
      clear = 1'b0;
      sel = 3'd3;
      repeat (2) @(negedge clk);
      checks++;
      if ({num_throws, total, count_sel} !== '0) begin
         failures++;
         $display("FAIL clear_stats got nt=%0d tot=%0d cs3=%0d required 0 0 0", num_throws, total, count_sel);
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 1; f <= 6; f++) begin
         do_roll(1, 3'(f));
         push_capture(3'(f));
         repeat (3) @(negedge clk);
      end
      for (int s = 0; s < 8; s++) begin
         logic [CNT_W-1:0] exp_cs;
         exp_cs = (s >= 1 && s <= 6) ? 8'd1 : 8'd0;
         sel = 3'(s);
         repeat (2) @(negedge clk);
         checks++;
         if (count_sel !== exp_cs) begin
            failures++;
            $display("FAIL count_sel sel=%0d got %0d required %0d", s, count_sel, exp_cs);
         end
      end
      checks++;
      if ({num_throws, total} !== {8'd6, 12'd21}) begin
         failures++;
         $display("FAIL b2b_stats got nt=%0d tot=%0d required 6 21", num_throws, total);
      end
   endtask

   task automatic test_settle_ignore();
      do_roll(2, 3'd5);
      push_capture(3'd5);
      @(posedge clk);   // enters SETTLE
      @(negedge clk);
      button = 1'b1;    // press during SETTLE, then keep holding
      repeat (6) @(negedge clk);
      checks++;
      if ({busy, result} !== {1'b0, 3'd5}) begin
         failures++;
         $display("FAIL held_button got busy=%0b result=%0d required 0 5", busy, result);
      end
      button = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      sel = 3'd6;
      for (int n = 0; n < 256; n++) begin
         do_roll(1, 3'd6);
         push_capture(3'd6);
         repeat (2) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({count_sel, num_throws, total} !== {8'd255, 8'd255, 12'd1536}) begin
         failures++;
         $display("FAIL saturation got cs6=%0d nt=%0d tot=%0d required 255 255 1536", count_sel, num_throws, total);
      end
   endtask

   task automatic test_reset_abort();
      do_roll(8, 3'd2);
      button = 1'b1;    // undo the release: keep rolling
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, result, num_throws} !== '0) begin
         failures++;
         $display("FAIL async_reset got busy=%0b result=%0d nt=%0d required 0 0 0", busy, result, num_throws);
      end
      @(negedge clk);
      rst = 1'b1;       // button still held high
      last_result = 3'd0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL held_after_reset got busy=%0b required 0", busy);
      end
      button = 1'b0;
      @(negedge clk);
      button = 1'b1;
      throw  = 3'd2;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rearm got busy=%0b required 1", busy);
      end
      @(negedge clk);
      button = 1'b0;
      push_capture(3'd2);
      repeat (4) @(negedge clk);
      checks++;
      if ({result, num_throws, total} !== {3'd2, 8'd1, 12'd2}) begin
         failures++;
         $display("FAIL post_reset_roll got result=%0d nt=%0d tot=%0d required 2 1 2", result, num_throws, total);
      end
   endtask

   task automatic test_drain();
      int budget;
      budget = 20;
      while (sb_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got %0d pending required 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal_then_legal();
      test_timeout();
      test_clear_on_capture();
      test_back_to_back();
      test_settle_ignore();
      test_saturation();
      test_reset_abort();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
